// File: rtl/fifo_pop_stage.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pop_stage
// Purpose  : Drain stage for cva5_fifo. Pops the FIFO head into a 2-entry
//            elastic buffer and presents it on a valid/ready output port.
//            fifo_pop never depends on out_ready, which cuts the
//            consumer-to-FIFO timing path while still sustaining one
//            transfer per cycle. A flush sequence discards buffered entries
//            and drains the FIFO.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            fifo_valid/data - FIFO head (valid, data_out)
//            fifo_pop        - dequeue FIFO head this cycle
//            flush           - discard buffered and FIFO-resident entries
//            out_valid/data  - output entry (head of elastic buffer)
//            out_ready       - consumer accepts out_data
//            busy            - stage holds data or is flushing
//            stat_xfers      - accepted-transfer count
//            stat_stalls     - out_valid & ~out_ready cycle count
// Options  : FIFO_POP_STAGE_STATS_EN - enables the two statistics counters;
//            when undefined both stat outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_pop_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_valid,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic                  flush,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [31:0]           stat_xfers,
    output logic [31:0]           stat_stalls
);

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q,  head_d;
    logic [DATA_WIDTH-1:0] tail_q,  tail_d;
    logic                  w_accept;
    logic                  w_stall;

    // ------------------------------------------------------------------------
    // State / occupancy register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_RUN;
            count_q <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Payload slots carry no reset; count_q alone defines which are live.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_RUN:   if (flush) state_d = c_ST_FLUSH;
            c_ST_FLUSH: if (!flush && !fifo_valid) state_d = c_ST_RUN;
            default:    state_d = c_ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs. fifo_pop looks only at registered state and fifo_valid; it is
    // masked during rst so nothing is dequeued while the stage is reset.
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q == c_ST_RUN) && (count_q != 2'd0);
        out_data  = head_q;
        busy      = (state_q == c_ST_FLUSH) || (count_q != 2'd0);
        if (rst) begin
            fifo_pop = 1'b0;
        end else if (state_q == c_ST_FLUSH) begin
            fifo_pop = fifo_valid;
        end else begin
            fifo_pop = fifo_valid && (count_q != 2'd2);
        end
    end

    assign w_accept = out_valid && out_ready;
    assign w_stall  = out_valid && !out_ready;

    // ------------------------------------------------------------------------
    // Elastic buffer update. Flush wins over any push/accept, and a pop in
    // the flush cycle (or during FLUSH) is simply discarded.
    // ------------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if ((state_q == c_ST_FLUSH) || flush) begin
            count_d = 2'd0;
        end else if (fifo_pop && !w_accept) begin
            if (count_q == 2'd0) begin
                head_d = fifo_data;
            end else begin
                tail_d = fifo_data;
            end
            count_d = count_q + 2'd1;
        end else if (w_accept && !fifo_pop) begin
            head_d  = tail_q;
            count_d = count_q - 2'd1;
        end else if (w_accept && fifo_pop) begin
            // Only reachable with count_q == 1: replace the head in place.
            head_d = fifo_data;
        end
    end

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef FIFO_POP_STAGE_STATS_EN
    logic [31:0] stat_xfers_q,  stat_xfers_d;
    logic [31:0] stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_xfers_d  = stat_xfers_q  + {31'd0, w_accept};
        stat_stalls_d = stat_stalls_q + {31'd0, w_stall};
    end

    // Cleared by rst only; flush leaves the statistics intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfers_q  <= 32'd0;
            stat_stalls_q <= 32'd0;
        end else begin
            stat_xfers_q  <= stat_xfers_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_xfers  = stat_xfers_q;
    assign stat_stalls = stat_stalls_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_stall;
    assign stat_xfers     = 32'd0;
    assign stat_stalls    = 32'd0;
`endif

    // ------------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (rst)
        count_q <= 2'd2);
    a_pop_needs_valid: assert property (@(posedge clk) disable iff (rst)
        fifo_pop |-> fifo_valid);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_pop_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_pop_stage
// Purpose  : Self-checking bench for fifo_pop_stage. A queue models the
//            upstream FIFO; a second queue holds the expected delivery order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_pop_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_valid;
    logic [31:0] fifo_data;
    logic        fifo_pop;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        busy;
    logic [31:0] stat_xfers;
    logic [31:0] stat_stalls;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    bit          fifo_en = 1'b1;

    logic        s_pop, s_valid, s_busy, s_acc;
    logic [31:0] s_data, s_xfers, s_stalls;

    int checks = 0;
    int passed = 0;

    fifo_pop_stage #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .fifo_pop    (fifo_pop),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .stat_xfers  (stat_xfers),
        .stat_stalls (stat_stalls)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock: drive inputs at negedge, sample after settling, then let
    // the FIFO model dequeue on the edge if the DUT popped.
    task automatic cycle(input logic rdy, input logic fl, input logic rs);
        @(negedge clk);
        rst        = rs;
        flush      = fl;
        out_ready  = rdy;
        fifo_valid = fifo_en && (fifo_q.size() != 0);
        if (fifo_valid) fifo_data = fifo_q[0];
        else            fifo_data = 32'hDEAD_BEEF;
        #1;
        s_pop    = fifo_pop;
        s_valid  = out_valid;
        s_busy   = busy;
        s_data   = out_data;
        s_acc    = out_valid && out_ready;
        s_xfers  = stat_xfers;
        s_stalls = stat_stalls;
        @(posedge clk);
        if (s_pop && fifo_q.size() != 0) void'(fifo_q.pop_front());
    endtask

    task automatic test_reset();
        logic [31:0] e;
        fifo_q.push_back(32'h0000_00C5);
        exp_q.push_back(32'h0000_00C5);
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++; if (s_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", s_valid); else passed++;
            checks++; if (s_pop !== 1'b0) $display("FAIL rst_fifo_pop: got %b expected 0", s_pop); else passed++;
            checks++; if (s_busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", s_busy); else passed++;
        end
        checks++; if (s_xfers !== 32'd0) $display("FAIL rst_xfers: got %0d expected 0", s_xfers); else passed++;
        checks++; if (s_stalls !== 32'd0) $display("FAIL rst_stalls: got %0d expected 0", s_stalls); else passed++;
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_pop !== 1'b1) $display("FAIL rst_first_pop: got %b expected 1", s_pop); else passed++;
        checks++; if (s_valid !== 1'b0) $display("FAIL rst_first_valid: got %b expected 0", s_valid); else passed++;
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_valid !== 1'b1) $display("FAIL rst_entry_valid: got %b expected 1", s_valid); else passed++;
        if (s_acc && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if (s_data !== e) $display("FAIL rst_entry_data: got %h expected %h", s_data, e); else passed++;
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_busy !== 1'b0) $display("FAIL rst_idle_busy: got %b expected 0", s_busy); else passed++;
    endtask

    task automatic test_streaming();
        logic [31:0] e;
        logic [31:0] x0;
        x0 = s_xfers;
        for (int i = 0; i < 8; i++) begin
            fifo_q.push_back(32'h10 + i);
            exp_q.push_back(32'h10 + i);
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_pop !== 1'b1) $display("FAIL stream_first_pop: got %b expected 1", s_pop); else passed++;
        checks++; if (s_valid !== 1'b0) $display("FAIL stream_latency: got %b expected 0", s_valid); else passed++;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            checks++; if (s_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b expected 1", i, s_valid); else passed++;
            if (s_acc && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++; if (s_data !== e) $display("FAIL stream_data[%0d]: got %h expected %h", i, s_data, e); else passed++;
            end
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_valid !== 1'b0) $display("FAIL stream_end_valid: got %b expected 0", s_valid); else passed++;
        checks++; if (exp_q.size() != 0) $display("FAIL stream_delivered: got %0d left expected 0", exp_q.size()); else passed++;
`ifdef FIFO_POP_STAGE_STATS_EN
        checks++; if (s_xfers - x0 !== 32'd8) $display("FAIL stream_xfers: got %0d expected 8", s_xfers - x0); else passed++;
`else
        checks++; if (s_xfers !== 32'd0) $display("FAIL stream_xfers_off: got %0d expected 0", s_xfers); else passed++;
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        logic [31:0] st0;
        st0 = s_stalls;
        for (int i = 0; i < 6; i++) begin
            fifo_q.push_back(32'hA0 + i);
            exp_q.push_back(32'hA0 + i);
        end
        for (int c = 1; c <= 12; c++) begin
            cycle(!(c >= 3 && c <= 6), 1'b0, 1'b0);
            if (c >= 3 && c <= 6) begin
                checks++; if (s_valid !== 1'b1 || s_data !== 32'hA1)
                    $display("FAIL bp_hold[%0d]: got v=%b d=%h expected v=1 d=a1", c, s_valid, s_data); else passed++;
            end
            if (c >= 4 && c <= 6) begin
                checks++; if (s_pop !== 1'b0) $display("FAIL bp_no_pop[%0d]: got %b expected 0", c, s_pop); else passed++;
            end
            if (s_acc) begin
                if (exp_q.size() == 0) begin
                    checks++; $display("FAIL bp_extra: got %h expected nothing", s_data);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (s_data !== e) $display("FAIL bp_data: got %h expected %h", s_data, e); else passed++;
                end
            end
        end
        checks++; if (exp_q.size() != 0) $display("FAIL bp_delivered: got %0d left expected 0", exp_q.size()); else passed++;
        checks++; if (s_valid !== 1'b0) $display("FAIL bp_end_valid: got %b expected 0", s_valid); else passed++;
`ifdef FIFO_POP_STAGE_STATS_EN
        checks++; if (s_stalls - st0 !== 32'd4) $display("FAIL bp_stalls: got %0d expected 4", s_stalls - st0); else passed++;
`else
        checks++; if (s_stalls !== 32'd0) $display("FAIL bp_stalls_off: got %0d expected 0", s_stalls); else passed++;
`endif
    endtask

    task automatic test_flush();
        logic [31:0] e;
        int pops;
        for (int i = 0; i < 5; i++) begin
            fifo_q.push_back(32'hB0 + i);
            exp_q.push_back(32'hB0 + i);
        end
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        checks++; if (fifo_q.size() != 3) $display("FAIL fl_fifo_left: got %0d expected 3", fifo_q.size()); else passed++;
        cycle(1'b0, 1'b1, 1'b0);
        checks++; if (s_valid !== 1'b1 || s_pop !== 1'b0)
            $display("FAIL fl_full: got v=%b pop=%b expected v=1 pop=0", s_valid, s_pop); else passed++;
        exp_q.delete();
        pops = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            pops += int'(s_pop);
            checks++; if (s_valid !== 1'b0) $display("FAIL fl_valid[%0d]: got %b expected 0", i, s_valid); else passed++;
            checks++; if (s_busy !== 1'b1) $display("FAIL fl_busy[%0d]: got %b expected 1", i, s_busy); else passed++;
        end
        checks++; if (pops != 3) $display("FAIL fl_pops: got %0d expected 3", pops); else passed++;
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_busy !== 1'b0) $display("FAIL fl_busy_fall: got %b expected 0", s_busy); else passed++;
        fifo_q.push_back(32'h55);
        exp_q.push_back(32'h55);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_valid !== 1'b1) $display("FAIL fl_new_valid: got %b expected 1", s_valid); else passed++;
        if (s_acc && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++; if (s_data !== e) $display("FAIL fl_new_data: got %h expected %h", s_data, e); else passed++;
        end
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_flush_hold();
        bit nonempty;
        bit drained = 1'b0;
        fifo_q.push_back(32'hD0);
        fifo_q.push_back(32'hD1);
        for (int i = 0; i < 5; i++) begin
            fifo_q.push_back(32'hD2 + i);
            cycle(1'b1, 1'b1, 1'b0);
            checks++; if (s_valid !== 1'b0) $display("FAIL fh_valid[%0d]: got %b expected 0", i, s_valid); else passed++;
            checks++; if (s_pop !== 1'b1) $display("FAIL fh_pop[%0d]: got %b expected 1", i, s_pop); else passed++;
            if (i > 0) begin
                checks++; if (s_busy !== 1'b1) $display("FAIL fh_busy[%0d]: got %b expected 1", i, s_busy); else passed++;
            end
        end
        for (int i = 0; i < 10 && !drained; i++) begin
            nonempty = (fifo_q.size() != 0);
            cycle(1'b1, 1'b0, 1'b0);
            checks++; if (s_valid !== 1'b0) $display("FAIL fh_drain_valid[%0d]: got %b expected 0", i, s_valid); else passed++;
            checks++; if (s_busy !== 1'b1) $display("FAIL fh_drain_busy[%0d]: got %b expected 1", i, s_busy); else passed++;
            if (!nonempty) drained = 1'b1;
        end
        checks++; if (!drained) $display("FAIL fh_timeout: got fifo size %0d expected 0", fifo_q.size()); else passed++;
        cycle(1'b1, 1'b0, 1'b0);
        checks++; if (s_busy !== 1'b0) $display("FAIL fh_resume: got busy=%b expected 0", s_busy); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] e;
        int next = 0;
        int cyc  = 0;
        bit rs;
        while (cyc < 8000 && !(next == 1000 && exp_q.size() == 0)) begin
            while (fifo_q.size() < 4 && next < 1000) begin
                fifo_q.push_back(32'h1000 + next);
                exp_q.push_back(32'h1000 + next);
                next++;
            end
            fifo_en = ($urandom_range(0, 3) != 0);
            rs = (cyc == 400);
            cycle($urandom_range(0, 2) != 0, 1'b0, rs);
            if (rs) begin
                checks++; if (s_pop !== 1'b0) $display("FAIL rnd_rst_pop: got %b expected 0", s_pop); else passed++;
                fifo_q.delete();
                exp_q.delete();
            end else if (s_acc) begin
                if (exp_q.size() == 0) begin
                    checks++; $display("FAIL rnd_extra: got %h expected nothing", s_data);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (s_data !== e) $display("FAIL rnd_data: got %h expected %h", s_data, e); else passed++;
                end
            end
            if (cyc == 401) begin
                checks++; if (s_valid !== 1'b0) $display("FAIL rnd_post_rst_valid: got %b expected 0", s_valid); else passed++;
            end
            cyc++;
        end
        fifo_en = 1'b1;
        checks++; if (exp_q.size() != 0 || next != 1000)
            $display("FAIL rnd_complete: got %0d left, %0d pushed expected 0 left, 1000 pushed", exp_q.size(), next); else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        fifo_valid = 1'b0;
        fifo_data  = 32'd0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_flush_hold();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_pop_stage.md
Name: fifo_pop_stage

Overview:
Downstream drain stage for cva5_fifo.
- Consumes the FIFO's valid/data_out and generates its pop.
- Presents entries on a registered valid/ready output port through a 2-entry elastic buffer.
- Has no combinational path from out_ready to fifo_pop, which breaks the consumer-to-FIFO timing path while sustaining one transfer per cycle.
- Provides a flush sequence that discards buffered and FIFO-resident entries.

Parameters:
DATA_WIDTH, 32, width of fifo_data / out_data.

Ports:
clk  input  1  clock.
rst  input  1  reset, synchronous, active-high.
fifo_valid  input  1  FIFO holds at least one entry (FIFO valid).
fifo_data  input  DATA_WIDTH  FIFO head entry (FIFO data_out); meaningful when fifo_valid=1.
fifo_pop  output  1  dequeue FIFO head this cycle.
flush  input  1  discard all buffered and FIFO-resident entries.
out_valid  output  1  out_data valid.
out_data  output  DATA_WIDTH  head entry of the elastic buffer.
out_ready  input  1  consumer accepts out_data.
busy  output  1  stage holds data or is flushing.
stat_xfers  output  32  accepted-transfer count (stats feature).
stat_stalls  output  32  out_valid & ~out_ready cycle count (stats feature).

Behaviour:
- Reset (rst=1 at posedge):
  - state=RUN, count=0.
  - out_valid=0, busy=0, fifo_pop=0; stats counters cleared.
  - Reset mid-operation drops all buffered entries. FIFO contents are the FIFO's own concern, since it resets itself.
- Storage:
  - Two entries, head and tail; count in {0,1,2}.
  - out_data = head; out_valid = (count!=0) & (state==RUN).
- Handshakes:
  - accept = out_valid & out_ready.
  - fifo_pop = fifo_valid & (count<2) in RUN; in FLUSH, fifo_pop = fifo_valid.
  - fifo_pop depends only on registered state and fifo_valid, never on out_ready.
- Per-cycle update in RUN, with pop meaning fifo_pop:
  - pop & ~accept: the entry fills the first free slot; count+1.
  - accept & ~pop: tail shifts to head; count-1.
  - pop & accept:
    - count=1: head <= fifo_data; count stays 1.
    - count=2 cannot occur, since pop requires count<2.
  - Neither: hold.
- Latency: an entry present in the FIFO with count<2 appears on out_valid the next cycle.
- Throughput: with continuous fifo_valid and out_ready, the stage transfers one entry per cycle.
- Stall behaviour: if out_ready drops, the stage fills to count=2 and pop stops. Resuming out_ready drains to count=1 in one cycle, then returns to one transfer per cycle.
- State machine, RUN / FLUSH:
  - RUN -> FLUSH when flush=1. At that edge count<=0 and no entries are kept; a same-cycle pop is discarded.
  - FLUSH: out_valid=0, no writes to head/tail, count held 0. fifo_pop=fifo_valid, so the FIFO drains at one entry per cycle.
  - FLUSH -> RUN when flush=0 & fifo_valid=0. Otherwise stay in FLUSH.
  - flush asserted while in FLUSH: stays in FLUSH.
  - flush has priority over every push/accept event.
- busy = (state==FLUSH) | (count!=0).
- Underflow/overflow:
  - fifo_pop is never asserted with fifo_valid=0.
  - An assertion checks that count never exceeds 2 and that fifo_pop implies fifo_valid, disabled during rst.
- out_data is stable while out_valid & ~out_ready.

Optional Feature:
Macro FIFO_POP_STAGE_STATS_EN.
- Defined:
  - stat_xfers increments on accept; stat_stalls increments on out_valid & ~out_ready.
  - Both are 32-bit, wrap modulo 2^32, and clear on rst only (not on flush).
- Undefined: stat_xfers and stat_stalls tied to 0; no counter logic.

Test Plan:
1. Reset: hold rst 2 cycles with fifo_valid=1 -> out_valid=0, fifo_pop=0, busy=0 throughout; first pop is in the cycle after rst deasserts.
2. Streaming: FIFO preloaded with 0x10..0x17, out_ready=1 -> out_data 0x10..0x17 on 8 consecutive cycles, first one cycle after the first pop; stat_xfers=8 when STATS_EN is defined.
3. Backpressure: streaming 0xA0..0xA5, out_ready=0 for cycles 3-6 -> count saturates at 2, fifo_pop=0 while full, out_data holds 0xA1 stable; all six values delivered in order with none lost or duplicated; stat_stalls=4.
4. Flush: count=2 with 3 entries in the FIFO, flush pulsed 1 cycle -> out_valid=0 next cycle; fifo_pop high 3 cycles; return to RUN when fifo_valid=0; busy falls; new entry 0x55 is then delivered normally.
5. Flush held 5 cycles while the FIFO keeps refilling -> stays in FLUSH, out_valid=0 throughout, every FIFO entry popped; RUN resumes only after flush=0 and fifo_valid=0.
6. Random valid/ready toggling, 1000 entries with incrementing data, plus a mid-stream rst -> in-order delivery with no drops up to the reset; assertions are never violated.
